// File: rtl/pulse_driver.sv
// pulse_driver: step-pulse generator for six stepper axes.
// Accepts one move at a time (one-hot axis, non-zero count), drives DR with
// a setup interval ahead of the first step, emits the commanded number of
// PUL steps on the selected axis, then holds off new commands for a guard
// interval.
// Optional build macro PULSE_RAMP_EN adds a linear acceleration ramp over
// the first RAMP_STEPS steps.
module pulse_driver #(
   parameter int unsigned DATA_WIDTH   = 10,
   parameter int unsigned HALF_PERIOD  = 50,
   parameter int unsigned DIR_SETUP    = 10,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned RAMP_STEPS   = 8,
   parameter int unsigned RAMP_INC     = 25
) (
   input  logic                  sysclk,
   input  logic                  INIT,
   input  logic [5:0]            i_Motor,
   input  logic [DATA_WIDTH-1:0] PulseNum,
   input  logic [5:0]            DRIn,
   output logic [5:0]            PUL,
   output logic [5:0]            DR,
   output logic                  Busy,
   output logic                  Done
);

`ifdef PULSE_RAMP_EN
   localparam int unsigned MAX_HALF = HALF_PERIOD + RAMP_STEPS * RAMP_INC;
`else
   localparam int unsigned MAX_HALF = HALF_PERIOD;
`endif
   // The first guard cycle carries Done, so the guard never shrinks below one cycle.
   localparam int unsigned GUARD_LEN = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
   localparam int unsigned MAX_A     = (MAX_HALF > DIR_SETUP) ? MAX_HALF : DIR_SETUP;
   localparam int unsigned MAX_LEN   = (MAX_A > GUARD_LEN) ? MAX_A : GUARD_LEN;
   // The period counter holds (phase length - 1).
   localparam int unsigned CNT_W     = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_GUARD
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            axis_q, axis_d;
   logic [5:0]            dr_q, dr_d;
   logic [DATA_WIDTH-1:0] steps_q, steps_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic [CNT_W-1:0]      half_now_m1;
   logic [CNT_W-1:0]      half_next_m1;
   logic                  cmd_valid;

`ifdef PULSE_RAMP_EN
   localparam int unsigned IDX_W = (RAMP_STEPS < 1) ? 1 : $clog2(RAMP_STEPS + 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] idx_next;

   function automatic logic [CNT_W-1:0] half_m1(input logic [IDX_W-1:0] idx);
      if (32'(idx) < RAMP_STEPS)
         half_m1 = CNT_W'(HALF_PERIOD + (RAMP_STEPS - 32'(idx)) * RAMP_INC - 1);
      else
         half_m1 = CNT_W'(HALF_PERIOD - 1);
   endfunction

   // Half-period of the current step and of the step that follows it.
   always_comb begin
      idx_next     = (32'(idx_q) < RAMP_STEPS) ? idx_q + IDX_W'(1) : idx_q;
      half_now_m1  = half_m1(idx_q);
      half_next_m1 = half_m1(idx_next);
   end
`else
   // Ramp parameters remain on the parameter list; nothing depends on them here.
   logic unused_ramp_cfg;
   assign unused_ramp_cfg = ^{RAMP_STEPS, RAMP_INC};

   // Every step uses the same half-period.
   always_comb begin
      half_now_m1  = CNT_W'(HALF_PERIOD - 1);
      half_next_m1 = CNT_W'(HALF_PERIOD - 1);
   end
`endif

   // Command qualification: exactly one axis selected and a non-zero count.
   always_comb begin
      cmd_valid = $onehot(i_Motor) && (PulseNum != '0);
   end

   // Next-state and datapath updates for the move sequencer.
   always_comb begin
      state_d = state_q;
      axis_d  = axis_q;
      dr_d    = dr_q;
      steps_d = steps_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef PULSE_RAMP_EN
      idx_d   = idx_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_SETUP;
               axis_d  = i_Motor;
               dr_d    = DRIn;
               steps_d = PulseNum;
               cnt_d   = CNT_W'(DIR_SETUP - 1);
`ifdef PULSE_RAMP_EN
               idx_d   = '0;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_HIGH;
               cnt_d   = half_now_m1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (cnt_q == '0) begin
               state_d = S_LOW;
               cnt_d   = half_now_m1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_LOW: begin
            if (cnt_q == '0) begin
               steps_d = steps_q - DATA_WIDTH'(1);
               if (steps_q == DATA_WIDTH'(1)) begin
                  state_d = S_GUARD;
                  cnt_d   = CNT_W'(GUARD_LEN - 1);
                  done_d  = 1'b1;
               end else begin
                  state_d = S_HIGH;
                  cnt_d   = half_next_m1;
`ifdef PULSE_RAMP_EN
                  idx_d   = idx_next;
`endif
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GUARD: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; INIT abandons any move with no guard.
   always_ff @(posedge sysclk) begin
      if (INIT) begin
         state_q <= S_IDLE;
         axis_q  <= '0;
         dr_q    <= '0;
         steps_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef PULSE_RAMP_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         axis_q  <= axis_d;
         dr_q    <= dr_d;
         steps_q <= steps_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef PULSE_RAMP_EN
         idx_q   <= idx_d;
`endif
      end
   end

   // Output decode from registered state.
   always_comb begin
      Busy = (state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW);
      PUL  = (state_q == S_HIGH) ? axis_q : '0;
      DR   = dr_q;
      Done = done_q;
   end

endmodule
